output_port_allocator: RTL and testbench
========================================

# output_port_allocator

Switch-side responder for the route reservation protocol driven by each input port's control logic. It accepts route reservation requests from N input ports, grants each output port to at most one input at a time, holds the grant until the owner relieves it, and drives the crossbar select for every output. It sits in the switch between the N input port controllers and the crossbar.

## Interface
- N, 4, number of input ports and of output ports
- REQUEST_WIDTH, 2, width of one request field; must be >= $clog2(N)
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  reset, synchronous, active-high
- routeReserveRequestValid  input  N  bit i: input i presents a request
- routeReserveRequest  input  N*REQUEST_WIDTH  field [i*REQUEST_WIDTH +: REQUEST_WIDTH]: requested output index for input i
- routeRelieve  input  N  bit i: input i releases its output
- routeReserveStatus  output  N  bit i: input i currently owns an output; level, held until release
- outputBusy  output  N  bit o: output o is owned
- outputSelect  output  N*$clog2(N)  field o: index of the input owning output o; 0 when free

## Operation
- Per output o: a two-state FSM (FREE, BUSY), an owner register, and a priority pointer ptr[o].
- Eligible requesters of o: inputs i with routeReserveRequestValid[i]=1, request field == o, and routeReserveStatus[i]=0.
- Requests with a field value >= N are ignored.
- FREE with at least one eligible requester:
  - Grant the first eligible i found scanning ptr[o]+1, ptr[o]+2, ... modulo N.
  - Next state BUSY; owner <= i; ptr[o] <= i.
- BUSY with routeRelieve[owner]=1: next state FREE.
- routeRelieve from a non-owner is ignored.
- Requests are not latched. A request that is withdrawn before being granted is lost.
- An input owns at most one output at a time. routeReserveStatus[i] = OR over outputs o of (BUSY and owner==i).
- One input cannot win two outputs in the same cycle: the scans for outputs 0..N-1 are resolved in index order, and an input granted by a lower-index output is not eligible for higher-index outputs in that cycle.
- Reset: every FSM goes FREE, ptr[o] = N-1 (input 0 has top priority), all outputs 0. Reset mid-grant drops every ownership.

## Timing
- Grant latency: request valid seen at edge k -> routeReserveStatus, outputBusy and outputSelect updated after edge k, visible in cycle k+1.
- Release latency: routeRelieve seen at edge k -> status and busy low in cycle k+1.
- Re-grant bubble: an output released at edge k is FREE in cycle k+1 and can be granted at edge k+1 at the earliest. There is one idle cycle minimum.
- The releasing input becomes eligible again from cycle k+1.
- Simultaneous relieve and request from the same input: the relieve takes effect; the request is not eligible in that cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- ALLOC_ROUND_ROBIN_EN defined: priority pointer behaviour exactly as in Operation.
- ALLOC_ROUND_ROBIN_EN undefined: no pointer registers. Fixed priority applies: the lowest-index eligible input wins. All other behaviour is unchanged.

## Test plan
- Reset, then input 2 requests output 3 -> one cycle later: routeReserveStatus=4'b0100, outputBusy=4'b1000, outputSelect field 3 = 2.
- Inputs 0, 1 and 3 request output 1 in the same cycle after reset -> input 0 is granted. Input 0 relieves; the requests stay held -> after the bubble cycle, input 1 is granted (RR). Without the macro, input 0 is granted again if it re-requests, otherwise input 1.
- Input 1 owns output 0; input 1 asserts routeRelieve together with a request for output 2 -> output 0 is free the next cycle, input 1 is granted output 2 one cycle later.
- Input 3 asserts routeRelieve while it owns nothing, and input 2 requests field value 3 with N=3 -> no state change; all outputs stay 0.
- Input 0 requests output 0 and output 1 on consecutive cycles -> only output 0 is granted. The second request is ignored while status[0]=1.
- rst asserted while all 4 outputs are BUSY -> the next cycle shows all outputs 0. After reset the pointers are back at N-1, so input 0 wins a 4-way contention.

Source files
------------

// File: rtl/output_port_allocator_if.sv
// Route reservation bus between the input port controllers (master) and the
// output port allocator (slave).
interface output_port_allocator_if #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
);
  localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]               routeReserveRequestValid;
  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [N-1:0]               routeRelieve;
  logic [N-1:0]               routeReserveStatus;
  logic [N-1:0]               outputBusy;
  logic [N*SEL_WIDTH-1:0]     outputSelect;

  modport master (
    output routeReserveRequestValid,
    output routeReserveRequest,
    output routeRelieve,
    input  routeReserveStatus,
    input  outputBusy,
    input  outputSelect
  );

  modport slave (
    input  routeReserveRequestValid,
    input  routeReserveRequest,
    input  routeRelieve,
    output routeReserveStatus,
    output outputBusy,
    output outputSelect
  );
endinterface

// File: rtl/output_port_allocator.sv
// Grants each output port to at most one input and drives the crossbar selects.
// Define ALLOC_ROUND_ROBIN_EN for round-robin priority; otherwise lowest index wins.
module output_port_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output_port_allocator_if.slave bus
);
  localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FREE, BUSY} state_t;

  state_t               state [N];
  logic [SEL_WIDTH-1:0] owner [N];
`ifdef ALLOC_ROUND_ROBIN_EN
  logic [SEL_WIDTH-1:0] ptr [N];
`endif

  logic [N-1:0]           status_q;
  logic [N-1:0]           busy_q;
  logic [N*SEL_WIDTH-1:0] select_q;

  logic [N-1:0]           grant;
  logic [SEL_WIDTH-1:0]   grant_idx [N];
  logic [N-1:0]           relieve_hit;
  logic [N-1:0]           next_status;
  logic [N-1:0]           next_busy;
  logic [N*SEL_WIDTH-1:0] next_select;

  assign bus.routeReserveStatus = status_q;
  assign bus.outputBusy         = busy_q;
  assign bus.outputSelect       = select_q;

  // Outputs are arbitrated in index order; an input won by a lower output is
  // masked out for the higher ones. The priority scan runs from lowest to
  // highest priority so the final assignment is the winner.
  always_comb begin
    logic [N-1:0]         taken;
    logic [N-1:0]         eligible;
    logic [SEL_WIDTH-1:0] idx;
    taken    = '0;
    eligible = '0;
    idx      = '0;
    grant    = '0;
    for (int o = 0; o < N; o++) begin
      grant_idx[o] = '0;
      for (int i = 0; i < N; i++) begin
        eligible[i] = bus.routeReserveRequestValid[i] && !status_q[i] && !taken[i] &&
                      (int'(bus.routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) == o);
      end
      if (state[o] == FREE) begin
        for (int k = N; k >= 1; k--) begin
`ifdef ALLOC_ROUND_ROBIN_EN
          idx = SEL_WIDTH'((int'(ptr[o]) + k) % N);
`else
          idx = SEL_WIDTH'(k - 1);
`endif
          if (eligible[idx]) begin
            grant[o]     = 1'b1;
            grant_idx[o] = idx;
          end
        end
        if (grant[o]) begin
          taken[grant_idx[o]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    relieve_hit = '0;
    next_status = '0;
    next_busy   = '0;
    next_select = '0;
    for (int o = 0; o < N; o++) begin
      relieve_hit[o] = (state[o] == BUSY) && bus.routeRelieve[owner[o]];
      if (state[o] == FREE && grant[o]) begin
        next_busy[o]                           = 1'b1;
        next_select[o*SEL_WIDTH +: SEL_WIDTH]  = grant_idx[o];
        next_status[grant_idx[o]]              = 1'b1;
      end else if (state[o] == BUSY && !relieve_hit[o]) begin
        next_busy[o]                           = 1'b1;
        next_select[o*SEL_WIDTH +: SEL_WIDTH]  = owner[o];
        next_status[owner[o]]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        state[o] <= FREE;
        owner[o] <= '0;
`ifdef ALLOC_ROUND_ROBIN_EN
        ptr[o]   <= SEL_WIDTH'(N - 1);
`endif
      end
      status_q <= '0;
      busy_q   <= '0;
      select_q <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        case (state[o])
          FREE: begin
            if (grant[o]) begin
              state[o] <= BUSY;
              owner[o] <= grant_idx[o];
`ifdef ALLOC_ROUND_ROBIN_EN
              ptr[o]   <= grant_idx[o];
`endif
            end
          end
          BUSY: begin
            if (relieve_hit[o]) begin
              state[o] <= FREE;
            end
          end
          default: state[o] <= FREE;
        endcase
      end
      status_q <= next_status;
      busy_q   <= next_busy;
      select_q <= next_select;
    end
  end
endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: a 4-port instance plus a 3-port
// instance for out-of-range request fields.
module tb_output_port_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  output_port_allocator_if #(.N(4), .REQUEST_WIDTH(2)) bus4 ();
  output_port_allocator_if #(.N(3), .REQUEST_WIDTH(2)) bus3 ();

  output_port_allocator #(.N(4), .REQUEST_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  output_port_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] req,
                               input logic [3:0] relieve);
    bus4.routeReserveRequestValid = valid;
    bus4.routeReserveRequest      = req;
    bus4.routeRelieve             = relieve;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkMain(input string tag, input logic [3:0] status,
                           input logic [3:0] busy, input logic [7:0] sel);
    checkOutput({tag, ".status"}, {4'h0, bus4.routeReserveStatus}, {4'h0, status});
    checkOutput({tag, ".busy"},   {4'h0, bus4.outputBusy},         {4'h0, busy});
    checkOutput({tag, ".select"}, bus4.outputSelect,               sel);
  endtask

  task automatic checkSmall(input string tag, input logic [2:0] status,
                            input logic [2:0] busy, input logic [5:0] sel);
    checkOutput({tag, ".status"}, {5'h0, bus3.routeReserveStatus}, {5'h0, status});
    checkOutput({tag, ".busy"},   {5'h0, bus3.outputBusy},         {5'h0, busy});
    checkOutput({tag, ".select"}, {2'h0, bus3.outputSelect},       {2'h0, sel});
  endtask

  initial begin
    applyStimulus(4'b0000, 8'h00, 4'b0000);
    bus3.routeReserveRequestValid = '0;
    bus3.routeReserveRequest      = '0;
    bus3.routeRelieve             = '0;
    rst = 1'b1;
    tick();
    tick();
    checkMain("reset", 4'b0000, 4'b0000, 8'h00);
    checkSmall("reset3", 3'b000, 3'b000, 6'h00);
    rst = 1'b0;

    // input 2 -> output 3
    applyStimulus(4'b0100, 8'h30, 4'b0000);
    tick();
    checkMain("grant_in2_out3", 4'b0100, 4'b1000, 8'h80);
    applyStimulus(4'b0000, 8'h00, 4'b0100);
    tick();
    checkMain("release_in2", 4'b0000, 4'b0000, 8'h00);

    // inputs 0,1,3 contend for output 1
    applyStimulus(4'b1011, 8'h45, 4'b0000);
    tick();
    checkMain("contend_in0", 4'b0001, 4'b0010, 8'h00);
    applyStimulus(4'b1010, 8'h45, 4'b0001);
    tick();
    checkMain("bubble", 4'b0000, 4'b0000, 8'h00);
    applyStimulus(4'b1010, 8'h45, 4'b0000);
    tick();
    checkMain("regrant_in1", 4'b0010, 4'b0010, 8'h04);
    applyStimulus(4'b1001, 8'h45, 4'b0010);
    tick();
    checkMain("bubble2", 4'b0000, 4'b0000, 8'h00);
    applyStimulus(4'b1001, 8'h45, 4'b0000);
    tick();
`ifdef ALLOC_ROUND_ROBIN_EN
    checkMain("rr_in3", 4'b1000, 4'b0010, 8'h0C);
    applyStimulus(4'b0000, 8'h00, 4'b1000);
`else
    checkMain("fixed_in0", 4'b0001, 4'b0010, 8'h00);
    applyStimulus(4'b0000, 8'h00, 4'b0001);
`endif
    tick();
    checkMain("release_contend", 4'b0000, 4'b0000, 8'h00);

    // input 1 relieves output 0 while requesting output 2
    applyStimulus(4'b0010, 8'h00, 4'b0000);
    tick();
    checkMain("grant_in1_out0", 4'b0010, 4'b0001, 8'h01);
    applyStimulus(4'b0010, 8'h08, 4'b0010);
    tick();
    checkMain("relieve_and_req", 4'b0000, 4'b0000, 8'h00);
    applyStimulus(4'b0010, 8'h08, 4'b0000);
    tick();
    checkMain("grant_in1_out2", 4'b0010, 4'b0100, 8'h10);
    applyStimulus(4'b0000, 8'h00, 4'b0010);
    tick();
    checkMain("release_in1", 4'b0000, 4'b0000, 8'h00);

    // relieve from an input owning nothing
    applyStimulus(4'b0000, 8'h00, 4'b1000);
    tick();
    checkMain("stray_relieve", 4'b0000, 4'b0000, 8'h00);
    applyStimulus(4'b0000, 8'h00, 4'b0000);

    // N=3: field value 3 is ignored, field value 2 is granted
    bus3.routeReserveRequestValid = 3'b100;
    bus3.routeReserveRequest      = 6'h30;
    tick();
    checkSmall("n3_out_of_range", 3'b000, 3'b000, 6'h00);
    bus3.routeReserveRequest      = 6'h20;
    tick();
    checkSmall("n3_grant_in2", 3'b100, 3'b100, 6'h20);
    bus3.routeReserveRequestValid = 3'b000;
    bus3.routeRelieve             = 3'b100;
    tick();
    checkSmall("n3_release", 3'b000, 3'b000, 6'h00);
    bus3.routeRelieve             = 3'b000;

    // input 0 asks for output 0 then output 1
    applyStimulus(4'b0001, 8'h00, 4'b0000);
    tick();
    checkMain("one_owner_first", 4'b0001, 4'b0001, 8'h00);
    applyStimulus(4'b0001, 8'h01, 4'b0000);
    tick();
    checkMain("one_owner_second", 4'b0001, 4'b0001, 8'h00);
    applyStimulus(4'b0000, 8'h00, 4'b0001);
    tick();
    checkMain("one_owner_release", 4'b0000, 4'b0000, 8'h00);

    // every output busy, then reset
    applyStimulus(4'b1111, 8'hE4, 4'b0000);
    tick();
    checkMain("all_busy", 4'b1111, 4'b1111, 8'hE4);
    applyStimulus(4'b0000, 8'h00, 4'b0000);
    rst = 1'b1;
    tick();
    checkMain("mid_grant_reset", 4'b0000, 4'b0000, 8'h00);
    rst = 1'b0;
    applyStimulus(4'b1111, 8'hAA, 4'b0000);
    tick();
    checkMain("post_reset_contend", 4'b0001, 4'b0100, 8'h00);
    applyStimulus(4'b0000, 8'h00, 4'b0000);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
